// File: rtl/trap_pkg.sv
// Shared encodings for the trap sequencer: CSR-unit op codes, trap causes and FSM states.
package trap_pkg;

    localparam logic [2:0] OP_TRAP  = 3'b000;
    localparam logic [2:0] OP_MRET  = 3'b001;
    localparam logic [2:0] OP_CSRRW = 3'b101;
    localparam logic [2:0] OP_CSRRS = 3'b110;
    localparam logic [2:0] OP_CSRRC = 3'b111;

    localparam logic [4:0] CAUSE_EXT_INT = 5'b11011;
    localparam logic [4:0] CAUSE_SW_INT  = 5'b10011;
    localparam logic [4:0] CAUSE_ILLEGAL = 5'b00010;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StBusy,
        StGap,
        StResp
    } state_e;

    // Ops whose response is a PC redirect rather than CSR read data.
    function automatic logic is_redirect_op(logic [2:0] op);
        return (op == OP_TRAP) || (op == OP_MRET);
    endfunction

endpackage

// File: rtl/trap_sequencer.sv
// Trap sequencer: serialises core requests and interrupts onto the CSR-unit handshake and
// turns CSR faults into illegal-instruction traps. One response per accepted request.
// Optional build macro TRAP_SEQUENCER_STATS_EN enables the wrapping trap_count_o counter;
// without it trap_count_o is tied to zero.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4,
    parameter logic [4:0]  ILLEGAL_CAUSE  = CAUSE_ILLEGAL
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [11:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [31:0] req_pc_i,
    input  logic        int_window_i,
    input  logic [31:0] int_pc_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        resp_redirect_o,
    output logic        resp_fault_o,
    output logic        seq_error_o,
    output logic        csr_available_o,
    output logic [2:0]  csr_op_o,
    output logic [11:0] csr_addr_exception_o,
    output logic [31:0] csr_write_value_o,
    input  logic [31:0] csr_read_value_i,
    input  logic        csr_ext_int_pending_i,
    input  logic        csr_sw_int_pending_i,
    input  logic        csr_busy_i,
    input  logic        csr_fault_i,
    output logic [31:0] trap_count_o
);

    localparam logic [3:0] TimeoutLimit = 4'(TIMEOUT_CYCLES);

    state_e      state_q;
    logic [2:0]  op_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic        conv_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        csr_available_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic        resp_redirect_q;
    logic        resp_fault_q;
    logic        seq_error_q;

    // Sequencer FSM; all outputs are registered and set alongside the state they belong to.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            op_q            <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            pc_q            <= '0;
            conv_q          <= 1'b0;
            cnt_q           <= '0;
            req_ready_q     <= 1'b1;
            csr_available_q <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_redirect_q <= 1'b0;
            resp_fault_q    <= 1'b0;
            seq_error_q     <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        op_q            <= req_op_i;
                        addr_q          <= req_addr_i;
                        wdata_q         <= req_wdata_i;
                        pc_q            <= req_pc_i;
                        conv_q          <= 1'b0;
                        cnt_q           <= '0;
                        req_ready_q     <= 1'b0;
                        csr_available_q <= 1'b1;
                        state_q         <= StIssue;
                    end else if (int_window_i && (csr_ext_int_pending_i || csr_sw_int_pending_i)) begin
                        op_q            <= OP_TRAP;
                        addr_q          <= {7'b0, csr_ext_int_pending_i ? CAUSE_EXT_INT
                                                                        : CAUSE_SW_INT};
                        wdata_q         <= int_pc_i;
                        pc_q            <= int_pc_i;
                        conv_q          <= 1'b0;
                        cnt_q           <= '0;
                        req_ready_q     <= 1'b0;
                        csr_available_q <= 1'b1;
                        state_q         <= StIssue;
                    end
                end
                StIssue: begin
                    if (csr_busy_i) begin
                        state_q <= StBusy;
                    end else if (cnt_q + 4'd1 == TimeoutLimit) begin
                        // CSR unit never picked the op up: give up with a zero response.
                        seq_error_q     <= 1'b1;
                        resp_data_q     <= '0;
                        resp_redirect_q <= is_redirect_op(op_q);
                        resp_fault_q    <= conv_q;
                        resp_valid_q    <= 1'b1;
                        csr_available_q <= 1'b0;
                        state_q         <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StBusy: begin
                    if (!csr_busy_i) begin
                        if (csr_fault_i && !conv_q) begin
                            // Replay as an illegal-instruction trap at the faulting PC.
                            op_q            <= OP_TRAP;
                            addr_q          <= {7'b0, ILLEGAL_CAUSE};
                            wdata_q         <= pc_q;
                            conv_q          <= 1'b1;
                            csr_available_q <= 1'b0;
                            state_q         <= StGap;
                        end else begin
                            if (csr_fault_i) begin
                                seq_error_q <= 1'b1;
                            end
                            resp_data_q     <= csr_read_value_i;
                            resp_redirect_q <= is_redirect_op(op_q);
                            resp_fault_q    <= conv_q;
                            resp_valid_q    <= 1'b1;
                            csr_available_q <= 1'b0;
                            state_q         <= StResp;
                        end
                    end
                end
                StGap: begin
                    cnt_q           <= '0;
                    csr_available_q <= 1'b1;
                    state_q         <= StIssue;
                end
                StResp: begin
                    req_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: begin
                    req_ready_q     <= 1'b1;
                    csr_available_q <= 1'b0;
                    state_q         <= StIdle;
                end
            endcase
        end
    end

`ifdef TRAP_SEQUENCER_STATS_EN
    logic [31:0] trap_count_q;

    // Count every trap-type response, including interrupts and converted faults.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trap_count_q <= '0;
        end else if (state_q == StResp && op_q == OP_TRAP) begin
            trap_count_q <= trap_count_q + 32'd1;
        end
    end

    assign trap_count_o = trap_count_q;
`else
    assign trap_count_o = '0;
`endif

    assign req_ready_o          = req_ready_q;
    assign resp_valid_o         = resp_valid_q;
    assign resp_data_o          = resp_data_q;
    assign resp_redirect_o      = resp_redirect_q;
    assign resp_fault_o         = resp_fault_q;
    assign seq_error_o          = seq_error_q;
    assign csr_available_o      = csr_available_q;
    assign csr_op_o             = op_q;
    assign csr_addr_exception_o = addr_q;
    assign csr_write_value_o    = wdata_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with a small behavioural CSR unit.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        int_window;
    logic [31:0] int_pc;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_redirect;
    logic        resp_fault;
    logic        seq_error;
    logic        csr_available;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr_exception;
    logic [31:0] csr_write_value;
    logic [31:0] csr_read_value;
    logic        ext_pend;
    logic        sw_pend;
    logic        csr_busy;
    logic        csr_fault;
    logic [31:0] trap_count;

    // CSR unit model controls
    logic        no_busy;
    logic        fault_all;
    logic [1:0]  avail_cnt = '0;
    logic [31:0] mepc = '0;
    logic [11:0] last_addr = '0;
    logic [31:0] last_wval = '0;
    logic        gap_avail;

    int vectors = 0;
    int miscompares = 0;

    trap_sequencer dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .req_valid_i           (req_valid),
        .req_ready_o           (req_ready),
        .req_op_i              (req_op),
        .req_addr_i            (req_addr),
        .req_wdata_i           (req_wdata),
        .req_pc_i              (req_pc),
        .int_window_i          (int_window),
        .int_pc_i              (int_pc),
        .resp_valid_o          (resp_valid),
        .resp_data_o           (resp_data),
        .resp_redirect_o       (resp_redirect),
        .resp_fault_o          (resp_fault),
        .seq_error_o           (seq_error),
        .csr_available_o       (csr_available),
        .csr_op_o              (csr_op),
        .csr_addr_exception_o  (csr_addr_exception),
        .csr_write_value_o     (csr_write_value),
        .csr_read_value_i      (csr_read_value),
        .csr_ext_int_pending_i (ext_pend),
        .csr_sw_int_pending_i  (sw_pend),
        .csr_busy_i            (csr_busy),
        .csr_fault_i           (csr_fault),
        .trap_count_o          (trap_count)
    );

    always #5 clk = ~clk;

    // CSR unit: busy for one cycle in the second available cycle, result valid the cycle after.
    assign csr_busy = csr_available && (avail_cnt == 2'd1) && !no_busy;

    always_comb begin
        csr_read_value = 32'h0;
        csr_fault      = fault_all;
        case (csr_op)
            3'b000: csr_read_value = 32'h10;
            3'b001: csr_read_value = mepc;
            default: begin
                if (csr_addr_exception == 12'h300) csr_read_value = 32'h8;
                if (csr_op == 3'b101 && csr_addr_exception == 12'h341) csr_fault = 1'b1;
            end
        endcase
    end

    always @(posedge clk) begin
        if (!csr_available) avail_cnt <= 2'd0;
        else if (avail_cnt != 2'd3) avail_cnt <= avail_cnt + 2'd1;
        if (csr_available && avail_cnt == 2'd2 && !no_busy) begin
            last_addr <= csr_addr_exception;
            last_wval <= csr_write_value;
            if (!csr_fault && csr_op == 3'b000) mepc <= csr_write_value;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request (or interrupt window) and check the response it produces.
    task automatic run_op(input string tag, input bit is_int, input logic [2:0] op,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc, input int exp_lat,
                          input logic [31:0] exp_data, input logic exp_redir,
                          input logic exp_fault);
        int n;
        @(negedge clk);
        check_val({tag, "/ready"}, {31'b0, req_ready}, 32'd1);
        if (is_int) begin
            int_window = 1'b1;
            int_pc     = wdata;
        end else begin
            req_valid = 1'b1;
            req_op    = op;
            req_addr  = addr;
            req_wdata = wdata;
            req_pc    = pc;
        end
        @(negedge clk);
        req_valid  = 1'b0;
        int_window = 1'b0;
        n = 1;
        gap_avail = 1'b1;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 4) gap_avail = csr_available;
        end
        check_val({tag, "/latency"}, 32'(n), 32'(exp_lat));
        check_val({tag, "/data"}, resp_data, exp_data);
        check_val({tag, "/redirect"}, {31'b0, resp_redirect}, {31'b0, exp_redir});
        check_val({tag, "/fault"}, {31'b0, resp_fault}, {31'b0, exp_fault});
        check_val({tag, "/ready_in_resp"}, {31'b0, req_ready}, 32'd0);
    endtask

    initial begin
        bit saw_resp;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_pc     = '0;
        int_window = 1'b0;
        int_pc     = '0;
        ext_pend   = 1'b0;
        sw_pend    = 1'b0;
        no_busy    = 1'b0;
        fault_all  = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst/ready", {31'b0, req_ready}, 32'd1);
        check_val("rst/resp_valid", {31'b0, resp_valid}, 32'd0);
        check_val("rst/avail", {31'b0, csr_available}, 32'd0);
        check_val("rst/op", {29'b0, csr_op}, 32'd0);
        check_val("rst/addr", {20'b0, csr_addr_exception}, 32'd0);
        check_val("rst/wval", csr_write_value, 32'd0);
        check_val("rst/seq_error", {31'b0, seq_error}, 32'd0);
        rst = 1'b0;

        // CSRRS mstatus: plain read, 4-cycle latency
        run_op("csrrs", 1'b0, 3'b110, 12'h300, 32'h0, 32'h80, 4, 32'h8, 1'b0, 1'b0);

        // CSRRW mepc faults: converted into illegal trap at req_pc
        run_op("conv", 1'b0, 3'b101, 12'h341, 32'hABCD, 32'h100, 8, 32'h10, 1'b1, 1'b1);
        check_val("conv/gap_avail", {31'b0, gap_avail}, 32'd0);
        check_val("conv/trap_addr", {20'b0, last_addr}, 32'h002);
        check_val("conv/trap_wval", last_wval, 32'h100);

        // Both interrupts pending: external wins
        ext_pend = 1'b1;
        sw_pend  = 1'b1;
        run_op("ext_int", 1'b1, 3'b000, 12'h0, 32'h200, 32'h0, 4, 32'h10, 1'b1, 1'b0);
        check_val("ext_int/addr", {20'b0, last_addr}, 32'h01B);
        check_val("ext_int/wval", last_wval, 32'h200);
        ext_pend = 1'b0;
        run_op("sw_int", 1'b1, 3'b000, 12'h0, 32'h240, 32'h0, 4, 32'h10, 1'b1, 1'b0);
        check_val("sw_int/addr", {20'b0, last_addr}, 32'h013);
        sw_pend = 1'b0;

        // Trap then MRET returns to the trap's saved PC
        run_op("trap", 1'b0, 3'b000, 12'h003, 32'h1234, 32'h1234, 4, 32'h10, 1'b1, 1'b0);
        run_op("mret", 1'b0, 3'b001, 12'h000, 32'h0, 32'h1300, 4, 32'h1234, 1'b1, 1'b0);

        // Fault on the converted trap itself: sticky error, value still returned
        fault_all = 1'b1;
        check_val("pre_err/seq_error", {31'b0, seq_error}, 32'd0);
        run_op("conv_err", 1'b0, 3'b110, 12'h300, 32'h0, 32'h400, 8, 32'h10, 1'b1, 1'b1);
        check_val("conv_err/seq_error", {31'b0, seq_error}, 32'd1);
        fault_all = 1'b0;

`ifdef TRAP_SEQUENCER_STATS_EN
        check_val("trap_count", trap_count, 32'd5);
`else
        check_val("trap_count", trap_count, 32'd0);
`endif

        // Reset while in BUSY: immediate return to idle, no response
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b110;
        req_addr  = 12'h300;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rstbusy/pre_avail", {31'b0, csr_available}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("rstbusy/avail", {31'b0, csr_available}, 32'd0);
        check_val("rstbusy/ready", {31'b0, req_ready}, 32'd1);
        check_val("rstbusy/seq_error", {31'b0, seq_error}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw_resp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        check_val("rstbusy/no_resp", {31'b0, saw_resp}, 32'd0);

        // CSR unit never goes busy: timeout after 4 ISSUE cycles
        no_busy = 1'b1;
        run_op("timeout", 1'b0, 3'b110, 12'h300, 32'h0, 32'h500, 5, 32'h0, 1'b0, 1'b0);
        check_val("timeout/seq_error", {31'b0, seq_error}, 32'd1);
        no_busy = 1'b0;
        run_op("after_to", 1'b0, 3'b110, 12'h300, 32'h0, 32'h600, 4, 32'h8, 1'b0, 1'b0);
        check_val("after_to/seq_error", {31'b0, seq_error}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
